// File: rtl/uart_tx.sv
// uart_tx: serialises one byte per valid/ready handshake into a start/data/parity/stop frame
module uart_tx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [2:0]           bit_idx, bit_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 par, par_nxt;
  logic                 tx_nxt, busy_nxt, done_nxt;
  logic                 xfer, bit_end;

  assign in_ready = rst_n && en && (state == IDLE);
  assign xfer     = in_valid && in_ready;
  assign bit_end  = cnt == CLK_LAST;

  // State, datapath and registered outputs; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shreg   <= shreg_nxt;
      par     <= par_nxt;
      tx      <= tx_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // Frame sequencing: clock counter wraps per bit, bit counter tracks data and stop bits
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (state == IDLE || bit_end) ? '0 : cnt + CW'(1);
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    par_nxt   = par;
    case (state)
      IDLE: if (xfer) begin
        state_nxt = START;
        shreg_nxt = in_data;
        par_nxt   = (PARITY == 2) ? ~^in_data : ^in_data;
        bit_nxt   = '0;
      end
      START: if (bit_end) state_nxt = DATA;
      DATA: if (bit_end) begin
        shreg_nxt = shreg << 1;
        bit_nxt   = (bit_idx == DATA_LAST) ? 3'd0 : bit_idx + 3'd1;
        state_nxt = (bit_idx != DATA_LAST) ? DATA : (PARITY != 0) ? PAR : STOP;
      end
      PAR: if (bit_end) state_nxt = STOP;
      STOP: if (bit_end) begin
        bit_nxt   = (bit_idx == STOP_LAST) ? 3'd0 : bit_idx + 3'd1;
        state_nxt = (bit_idx == STOP_LAST) ? IDLE : STOP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so the registered line matches it
  always_comb begin
    tx_nxt   = (state_nxt == START) ? 1'b0 :
               (state_nxt == DATA)  ? shreg_nxt[DATA_BITS-1] :
               (state_nxt == PAR)   ? par_nxt : 1'b1;
    busy_nxt = state_nxt != IDLE;
    done_nxt = (state_nxt == STOP) && (cnt_nxt == CLK_LAST) && (bit_nxt == STOP_LAST);
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized and directed checks of uart_tx against a frame-level reference model
module tb_uart_tx;
  localparam int CPB[4] = '{1, 4, 4, 3};
  localparam int DB[4]  = '{8, 8, 8, 6};
  localparam int PAR[4] = '{0, 1, 2, 1};
  localparam int SB[4]  = '{1, 1, 1, 2};

  typedef bit bq_t[$];

  logic       clk = 1'b0;
  logic       rst_n[4], en[4], valid[4], rdy[4], tx[4], busy[4], done[4];
  logic [7:0] data[4];
  logic [63:0] trace;
  logic       pbit;
  int         n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB[0]), .DATA_BITS(DB[0]), .PARITY(PAR[0]), .STOP_BITS(SB[0])) u0 (
    .clk(clk), .rst_n(rst_n[0]), .en(en[0]), .in_valid(valid[0]), .in_data(data[0][7:0]),
    .in_ready(rdy[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0]));
  uart_tx #(.CLKS_PER_BIT(CPB[1]), .DATA_BITS(DB[1]), .PARITY(PAR[1]), .STOP_BITS(SB[1])) u1 (
    .clk(clk), .rst_n(rst_n[1]), .en(en[1]), .in_valid(valid[1]), .in_data(data[1][7:0]),
    .in_ready(rdy[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1]));
  uart_tx #(.CLKS_PER_BIT(CPB[2]), .DATA_BITS(DB[2]), .PARITY(PAR[2]), .STOP_BITS(SB[2])) u2 (
    .clk(clk), .rst_n(rst_n[2]), .en(en[2]), .in_valid(valid[2]), .in_data(data[2][7:0]),
    .in_ready(rdy[2]), .tx(tx[2]), .busy(busy[2]), .done(done[2]));
  uart_tx #(.CLKS_PER_BIT(CPB[3]), .DATA_BITS(DB[3]), .PARITY(PAR[3]), .STOP_BITS(SB[3])) u3 (
    .clk(clk), .rst_n(rst_n[3]), .en(en[3]), .in_valid(valid[3]), .in_data(data[3][5:0]),
    .in_ready(rdy[3]), .tx(tx[3]), .busy(busy[3]), .done(done[3]));

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line level for every clock of one frame
  function automatic bq_t frame(int k, logic [7:0] b);
    bq_t q;
    bit  seq[$];
    int  ones = 0;
    seq.push_back(1'b0);
    for (int i = DB[k] - 1; i >= 0; i--) begin
      seq.push_back(b[i]);
      ones += int'(b[i]);
    end
    if (PAR[k] != 0) seq.push_back(bit'(PAR[k] == 1 ? ones % 2 : 1 - ones % 2));
    for (int i = 0; i < SB[k]; i++) seq.push_back(1'b1);
    foreach (seq[j]) repeat (CPB[k]) q.push_back(seq[j]);
    return q;
  endfunction

  // Called at a negedge; returns at the negedge of the first idle clock (or after an abort)
  task automatic send(int k, logic [7:0] b, bit hold, int abort_at, int drop_at);
    bq_t exp;
    int  t = 0;
    exp = frame(k, b);
    valid[k] = 1'b1;
    data[k]  = b;
    while (!rdy[k] && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!rdy[k]) begin
      chk("ready_timeout", 0, 1);
      valid[k] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) valid[k] = 1'b0;
    trace = '0;
    for (int i = 0; i < exp.size(); i++) begin
      trace = {trace[62:0], tx[k]};
      if (i == (1 + DB[k]) * CPB[k]) pbit = tx[k];
      chk("tx", tx[k], exp[i]);
      chk("busy", busy[k], 1);
      chk("done", done[k], i == exp.size() - 1);
      chk("ready_in_frame", rdy[k], 0);
      if (i == abort_at) begin
        rst_n[k] = 1'b0;
        valid[k] = 1'b0;
        @(negedge clk);
        chk("abort_tx", tx[k], 1);
        chk("abort_busy", busy[k], 0);
        chk("abort_done", done[k], 0);
        chk("abort_ready", rdy[k], 0);
        rst_n[k] = 1'b1;
        repeat (4) begin
          @(negedge clk);
          chk("post_abort_done", done[k], 0);
          chk("post_abort_tx", tx[k], 1);
        end
        return;
      end
      if (i == drop_at) en[k] = 1'b0;
      @(negedge clk);
    end
    chk("idle_tx", tx[k], 1);
    chk("idle_busy", busy[k], 0);
    chk("idle_done", done[k], 0);
    chk("idle_ready", rdy[k], en[k]);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] q3[3];
    for (int k = 0; k < 4; k++) begin
      rst_n[k] = 1'b0; en[k] = 1'b1; valid[k] = 1'b0; data[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("reset_tx", tx[k], 1);
      chk("reset_busy", busy[k], 0);
      chk("reset_done", done[k], 0);
      chk("reset_ready", rdy[k], 0);
      rst_n[k] = 1'b1;
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk("ready_after_reset", rdy[k], 1);

    send(0, 8'hA5, 0, -1, -1);
    chk("a5_trace", trace[9:0], 10'b0101001011);
    foreach (q3[i]) q3[i] = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'h3C;
    foreach (q3[i]) send(0, q3[i], 0, -1, -1);

    send(1, 8'hA5, 0, -1, -1);
    chk("even_parity_a5", pbit, 0);
    send(2, 8'hA5, 0, -1, -1);
    chk("odd_parity_a5", pbit, 1);
    send(3, 8'h2B, 0, -1, -1);

    for (int k = 0; k < 4; k++) begin
      foreach (q3[i]) q3[i] = 8'($urandom);
      foreach (q3[i]) send(k, q3[i], 1, -1, -1);
      valid[k] = 1'b0;
      repeat (20) begin
        @(negedge clk);
        chk("no_extra_frame", busy[k], 0);
      end
    end

    for (int k = 0; k < 4; k++) begin
      send(k, 8'($urandom), 0, 4 * CPB[k], -1);
      send(k, 8'h81, 0, -1, -1);
    end

    send(0, 8'h5A, 1, -1, 3);
    repeat (6) begin
      @(negedge clk);
      chk("en_low_busy", busy[0], 0);
      chk("en_low_ready", rdy[0], 0);
    end
    en[0] = 1'b1;
    send(0, 8'h5A, 0, -1, -1);
    send(1, 8'hC3, 1, -1, 2 * CPB[1]);
    en[1] = 1'b1;
    send(1, 8'hC3, 0, -1, -1);

    for (int n = 0; n < 24; n++) send($urandom_range(0, 3), 8'($urandom), 0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
